// File: rtl/counter_step_sched_pkg.sv
// -----------------------------------------------------------------------------
// counter_sched_pkg
// Shared types and constants for the counter step scheduler.
//   state_t        : scheduler FSM states (IDLE / RUN / DONE)
//   DIR_UP/DOWN    : encoding of the per-requester direction bit
//   cmd_t          : latched command (direction + step size)
//   DEF_X/N/L      : default count width, modulus and length width
//   owner_onehot() : maps a requester index to its one-hot grant vector
// -----------------------------------------------------------------------------
package counter_sched_pkg;

  localparam int DEF_X = 3;
  localparam int DEF_N = 6;
  localparam int DEF_L = 4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       dir;
    logic [1:0] step;
  } cmd_t;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/counter_step_sched_step_counter.sv
// -----------------------------------------------------------------------------
// step_counter
// Shared modulo-N counter with a programmable step and direction.
//   clk, reset : clock, asynchronous active-high reset
//   i_en       : apply one update on this edge
//   i_dir      : DIR_UP / DIR_DOWN
//   i_step     : step size 0..3
//   o_count    : current count (held between updates)
//   o_wrap     : pulses in the cycle a wrapped value first appears on o_count
// Up  : count >= N-step -> 0 (wrap), else count+step.
// Down: count == 0      -> N-step (wrap), else count-step.
// A zero step never moves the counter and never wraps; this also covers the
// down-from-0 case whose raw result N is clamped back to 0.
// -----------------------------------------------------------------------------
module step_counter
  import counter_sched_pkg::*;
#(
  parameter int X = DEF_X,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_dir,
  input  logic [1:0]   i_step,
  output logic [X-1:0] o_count,
  output logic         o_wrap
);

  logic [X-1:0] r_count;
  logic         r_wrap;
  logic [X-1:0] w_next;
  logic         w_wrap;
  // Two guard bits so N (which may equal 2^X) and N-step fit without overflow.
  logic [X+1:0] w_cnt_ext;
  logic [X+1:0] w_thr;

  assign w_cnt_ext = {2'b00, r_count};
  assign w_thr     = (X+2)'(N) - (X+2)'(i_step);

  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    if (i_step == 2'd0) begin
      w_next = r_count;
    end else if (i_dir == DIR_UP) begin
      if (w_cnt_ext >= w_thr) begin
        w_next = '0;
        w_wrap = 1'b1;
      end else begin
        w_next = r_count + X'(i_step);
      end
    end else begin
      if (r_count == '0) begin
        w_next = w_thr[X-1:0];
        w_wrap = 1'b1;
      end else begin
        // A step larger than the count underflows modulo 2^X.
        w_next = r_count - X'(i_step);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= i_en & w_wrap;
      if (i_en) r_count <= w_next;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = r_wrap;

endmodule

// File: rtl/counter_step_sched.sv
// -----------------------------------------------------------------------------
// counter_step_sched
// Two-requester scheduler owning one shared step counter. A granted requester
// issues a latched command of len updates (dir, step); the owner gets a
// one-cycle done pulse, then the block idles for at least one cycle.
//   clk, reset        : clock, asynchronous active-high reset
//   req[1:0]          : request per requester
//   dir[1:0]          : per-requester direction (0 up, 1 down)
//   step0, step1      : per-requester step size 0..3
//   len0, len1        : per-requester number of counter updates
//   gnt[1:0]          : one-hot owner, 00 when idle
//   busy              : gnt nonzero
//   done[1:0]         : one-cycle completion pulse for the owner
//   count[X-1:0]      : shared counter value
//   wrap              : one-cycle pulse with a wrapped count value
// Optional feature, macro SCHED_ABORT_EN:
//   abort (in)        : in RUN, jump to DONE without an update on that edge
//   aborted (out)     : pulses together with done for an aborted command
// Arbitration: on simultaneous requests the requester not served last wins;
// last-served resets to requester 1 so requester 0 wins first.
// -----------------------------------------------------------------------------
module counter_step_sched
  import counter_sched_pkg::*;
#(
  parameter int X = DEF_X,
  parameter int N = DEF_N,
  parameter int L = DEF_L
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [1:0]   dir,
  input  logic [1:0]   step0,
  input  logic [1:0]   step1,
  input  logic [L-1:0] len0,
  input  logic [L-1:0] len1,
`ifdef SCHED_ABORT_EN
  input  logic         abort,
  output logic         aborted,
`endif
  output logic [1:0]   gnt,
  output logic         busy,
  output logic [1:0]   done,
  output logic [X-1:0] count,
  output logic         wrap
);

  state_t       r_state;
  state_t       w_next_state;
  logic         r_owner;
  logic         r_last;
  cmd_t         r_cmd;
  logic [L-1:0] r_rem;
  logic         w_win;
  logic         w_grant;
  logic         w_upd;
  logic         w_abort;

`ifdef SCHED_ABORT_EN
  logic r_aborted;
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Winner among pending requests; only meaningful when req != 0.
  always_comb begin
    w_win = 1'b0;
    case (req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  assign w_grant = (r_state == ST_IDLE) && (req != 2'b00);
  // Remaining==0 edge only retires the command; abort suppresses the update.
  assign w_upd   = (r_state == ST_RUN) && (r_rem != '0) && !w_abort;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (req != 2'b00) w_next_state = ST_RUN;
      ST_RUN:  if (w_abort || (r_rem == '0)) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs (gnt held through RUN and DONE)
  always_comb begin
    gnt  = 2'b00;
    done = 2'b00;
    busy = 1'b0;
    if (r_state != ST_IDLE) begin
      gnt  = owner_onehot(r_owner);
      busy = 1'b1;
    end
    if (r_state == ST_DONE) done = owner_onehot(r_owner);
  end

  // Command latch, remaining counter and last-served bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cmd   <= '0;
      r_rem   <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_win;
        r_cmd   <= w_win ? cmd_t'{dir: dir[1], step: step1}
                         : cmd_t'{dir: dir[0], step: step0};
        r_rem   <= w_win ? len1 : len0;
      end else if (w_upd) begin
        r_rem <= r_rem - 1'b1;
      end
      if (r_state == ST_DONE) r_last <= r_owner;
    end
  end

`ifdef SCHED_ABORT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_aborted <= 1'b0;
    else if (r_state == ST_RUN && abort)  r_aborted <= 1'b1;
    else if (r_state == ST_DONE)          r_aborted <= 1'b0;
  end

  assign aborted = (r_state == ST_DONE) && r_aborted;
`endif

  step_counter #(
    .X (X),
    .N (N)
  ) u_step_counter (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_upd),
    .i_dir   (r_cmd.dir),
    .i_step  (r_cmd.step),
    .o_count (count),
    .o_wrap  (wrap)
  );

endmodule

// File: tb/tb_counter_step_sched.sv
module tb_counter_step_sched;

  localparam int X = 3;
  localparam int N = 6;
  localparam int L = 4;

  logic         clk;
  logic         reset;
  logic [1:0]   req;
  logic [1:0]   dir;
  logic [1:0]   step0, step1;
  logic [L-1:0] len0, len1;
  logic [1:0]   gnt;
  logic         busy;
  logic [1:0]   done;
  logic [X-1:0] count;
  logic         wrap;
`ifdef SCHED_ABORT_EN
  logic         abort;
  logic         aborted;
`endif

  counter_step_sched #(.X(X), .N(N), .L(L)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .dir   (dir),
    .step0 (step0),
    .step1 (step1),
    .len0  (len0),
    .len1  (len1),
`ifdef SCHED_ABORT_EN
    .abort   (abort),
    .aborted (aborted),
`endif
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .count (count),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: shared count value and last-served requester.
  int model_cnt;
  int last_srv;
  int e_cnt  [16];
  int e_wrap [16];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Spec-level arithmetic for a single update; result kept within X bits.
  function automatic void ref_step(input int c, input int d, input int s,
                                   output int nc, output int w);
    nc = c;
    w  = 0;
    if (s == 0) begin
      nc = c;
    end else if (d == 0) begin
      if (c >= N - s) begin nc = 0; w = 1; end
      else nc = c + s;
    end else begin
      if (c == 0) begin nc = N - s; w = 1; end
      else nc = (c - s) & ((1 << X) - 1);
    end
  endfunction

  task automatic scramble();
    req   = 2'($urandom);
    dir   = 2'($urandom);
    step0 = 2'($urandom);
    step1 = 2'($urandom);
    len0  = L'($urandom);
    len1  = L'($urandom);
  endtask

  task automatic do_reset();
    req   = 2'b00;
`ifdef SCHED_ABORT_EN
    abort = 1'b0;
`endif
    reset = 1'b1;
    #4;
    reset = 1'b0;
    @(posedge clk); #1;
    model_cnt = 0;
    last_srv  = 1;
  endtask

  // Called #1 after a posedge with the DUT idle. Expected per-update values
  // must already be in e_cnt/e_wrap.
  task automatic run_txn(input logic [1:0] rq, input logic [1:0] dr,
                         input logic [1:0] s0, input logic [1:0] s1,
                         input logic [L-1:0] l0, input logic [L-1:0] l1,
                         input logic [1:0] eg, input string nm);
    int ln;
    int prev;
    req = rq; dir = dr; step0 = s0; step1 = s1; len0 = l0; len1 = l1;
    ln   = eg[1] ? int'(l1) : int'(l0);
    prev = model_cnt;
    @(posedge clk); #1;
    chk({nm, " grant gnt"}, int'(gnt), int'(eg));
    chk({nm, " grant busy"}, int'(busy), 1);
    chk({nm, " grant count"}, int'(count), prev);
    for (int i = 0; i < ln; i++) begin
      scramble();
      @(posedge clk); #1;
      chk($sformatf("%s upd%0d count", nm, i), int'(count), e_cnt[i]);
      chk($sformatf("%s upd%0d wrap", nm, i), int'(wrap), e_wrap[i]);
      chk($sformatf("%s upd%0d gnt", nm, i), int'(gnt), int'(eg));
      chk($sformatf("%s upd%0d done", nm, i), int'(done), 0);
    end
    @(posedge clk); #1;
    chk({nm, " done pulse"}, int'(done), int'(eg));
    chk({nm, " done gnt"}, int'(gnt), int'(eg));
    chk({nm, " done wrap"}, int'(wrap), 0);
    req = 2'b00;
    @(posedge clk); #1;
    chk({nm, " idle gnt"}, int'(gnt), 0);
    chk({nm, " idle done"}, int'(done), 0);
    chk({nm, " idle busy"}, int'(busy), 0);
    if (ln > 0) model_cnt = e_cnt[ln-1];
    last_srv = eg[1] ? 1 : 0;
  endtask

  typedef struct packed {
    logic [1:0]       rq;
    logic [1:0]       dr;
    logic [1:0]       s0;
    logic [1:0]       s1;
    logic [3:0]       l0;
    logic [3:0]       l1;
    logic [1:0]       eg;
    logic [3:0][2:0]  ecnt;
    logic [3:0]       ewrap;
  } vec_t;

  vec_t tbl [8];
  logic [1:0] pat [8];

  initial begin
    // Directed commands applied back to back from reset (count starts at 0).
    tbl[0] = '{2'b01, 2'b00, 2'd1, 2'd0, 4'd4, 4'd0, 2'b01, {3'd4, 3'd3, 3'd2, 3'd1}, 4'b0000};
    tbl[1] = '{2'b01, 2'b00, 2'd2, 2'd0, 4'd3, 4'd0, 2'b01, {3'd0, 3'd4, 3'd2, 3'd0}, 4'b0001};
    tbl[2] = '{2'b01, 2'b00, 2'd2, 2'd0, 4'd1, 4'd0, 2'b01, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0001};
    tbl[3] = '{2'b01, 2'b01, 2'd1, 2'd0, 4'd2, 4'd0, 2'b01, {3'd0, 3'd0, 3'd4, 3'd5}, 4'b0001};
    tbl[4] = '{2'b10, 2'b10, 2'd1, 2'd0, 4'd0, 4'd2, 2'b10, {3'd0, 3'd0, 3'd4, 3'd4}, 4'b0000};
    tbl[5] = '{2'b11, 2'b00, 2'd3, 2'd1, 4'd1, 4'd3, 2'b01, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0001};
    tbl[6] = '{2'b11, 2'b10, 2'd1, 2'd0, 4'd1, 4'd1, 2'b10, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000};
    tbl[7] = '{2'b01, 2'b00, 2'd1, 2'd0, 4'd0, 4'd0, 2'b01, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000};
    pat = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};

    reset = 1'b1;
    req = 2'b00; dir = 2'b00; step0 = 2'd0; step1 = 2'd0; len0 = '0; len1 = '0;
`ifdef SCHED_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    chk("reset gnt", int'(gnt), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset count", int'(count), 0);
    chk("reset wrap", int'(wrap), 0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    model_cnt = 0;
    last_srv  = 1;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) begin
        e_cnt[i]  = int'(tbl[v].ecnt[i]);
        e_wrap[i] = int'(tbl[v].ewrap[i]);
      end
      run_txn(tbl[v].rq, tbl[v].dr, tbl[v].s0, tbl[v].s1, tbl[v].l0, tbl[v].l1,
              tbl[v].eg, $sformatf("vec%0d", v));
    end

    // Randomized commands against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0]   rq, dr, s0, s1;
      logic [L-1:0] l0, l1;
      int win, d, s, ln, c, nc, w;
      rq = 2'($urandom_range(1, 3));
      dr = 2'($urandom);
      s0 = 2'($urandom);
      s1 = 2'($urandom);
      l0 = L'($urandom_range(0, 6));
      l1 = L'($urandom_range(0, 6));
      if (rq == 2'b01)      win = 0;
      else if (rq == 2'b10) win = 1;
      else                  win = (last_srv == 1) ? 0 : 1;
      d  = int'(dr[win]);
      s  = win ? int'(s1) : int'(s0);
      ln = win ? int'(l1) : int'(l0);
      c  = model_cnt;
      for (int i = 0; i < ln; i++) begin
        ref_step(c, d, s, nc, w);
        e_cnt[i]  = nc;
        e_wrap[i] = w;
        c = nc;
      end
      run_txn(rq, dr, s0, s1, l0, l1, win ? 2'b10 : 2'b01, $sformatf("rnd%0d", t));
    end

    // Both requesting continuously: alternating grants with an idle gap.
    do_reset();
    req = 2'b11; dir = 2'b00; step0 = 2'd1; step1 = 2'd1; len0 = 4'd1; len1 = 4'd1;
    @(posedge clk); #1;
    chk("alt first gnt", int'(gnt), 1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("alt cyc%0d gnt", k), int'(gnt), int'(pat[k]));
    end

    // Reset in the second RUN cycle: immediate clear, no done pulse.
    do_reset();
    req = 2'b01; dir = 2'b00; step0 = 2'd1; len0 = 4'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid-run count before reset", int'(count), 1);
    req = 2'b00;
    #1 reset = 1'b1;
    #1;
    chk("mid-run reset count", int'(count), 0);
    chk("mid-run reset gnt", int'(gnt), 0);
    chk("mid-run reset busy", int'(busy), 0);
    #1 reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (done != 2'b00 || gnt != 2'b00) seen++;
      end
      chk("mid-run reset no done", seen, 0);
    end

`ifdef SCHED_ABORT_EN
    do_reset();
    req = 2'b01; dir = 2'b00; step0 = 2'd1; len0 = 4'd8;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("abort pre count", int'(count), 3);
    abort = 1'b1;
    req = 2'b00;
    @(posedge clk); #1;
    chk("abort count frozen", int'(count), 3);
    chk("abort done", int'(done), 1);
    chk("abort aborted", int'(aborted), 1);
    abort = 1'b0;
    @(posedge clk); #1;
    chk("abort after done", int'(done), 0);
    chk("abort after aborted", int'(aborted), 0);
    chk("abort after gnt", int'(gnt), 0);
    chk("abort after count", int'(count), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
